// File: rtl/sd_csr.sv
// sd_csr: CPU register slave for the SD command/data engines and the RX/TX FIFO window.
// Latency: register access acks one cycle after the request; FIFO window reads ack 3 cycles after it when data is waiting.
// Backpressure: requests are ignored while o_busy; the FIFO window stalls up to FIFO_WAIT cycles, then acks and flags fifo_tmo.
//
// Ports:
//   i_clk, i_reset              clock, synchronous active-high reset
//   o_sd_config                 {dat_width, clk_config[1:0]}
//   o_command_* / i_command_*   command engine control and response/status
//   o_dat_* / i_dat_status      data engine control and status
//   o_rx_fifo_* / i_rx_fifo_*   RX FIFO pop/flush, empty flag and head word
//   o_tx_fifo_* / i_tx_fifo_full TX FIFO push/flush/data and full flag
//   o_irq                       |(pending & enable), registered
//   i_request .. o_data         CPU bus: one-cycle request, busy, one-cycle ack with read data
module sd_csr #(
   parameter int RSP_WORDS = 4,
   parameter int FIFO_WAIT = 15
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   // Command engine
   output logic [2:0]              o_sd_config,
   output logic [5:0]              o_command_index,
   output logic [31:0]             o_command_argument,
   output logic [1:0]              o_command_flags,
   output logic                    o_command_start,
   input  logic [5:0]              i_command_index,
   input  logic [32*RSP_WORDS-1:0] i_command_response,
   input  logic [2:0]              i_command_status,
   // Data engine
   output logic                    o_dat_direction,
   output logic [6:0]              o_dat_block_size,
   output logic [10:0]             o_dat_num_blocks,
   output logic                    o_dat_start,
   output logic                    o_dat_stop,
   input  logic [1:0]              i_dat_status,
   // RX FIFO
   output logic                    o_rx_fifo_flush,
   output logic                    o_rx_fifo_pop,
   input  logic                    i_rx_fifo_empty,
   input  logic [31:0]             i_rx_fifo_data,
   // TX FIFO
   output logic                    o_tx_fifo_flush,
   output logic                    o_tx_fifo_push,
   input  logic                    i_tx_fifo_full,
   output logic [31:0]             o_tx_fifo_data,
   // Interrupt
   output logic                    o_irq,
   // CPU register bus
   input  logic                    i_request,
   input  logic                    i_write,
   input  logic [3:0]              i_address,
   input  logic [31:0]             i_data,
   output logic                    o_busy,
   output logic                    o_ack,
   output logic [31:0]             o_data
);

   localparam int CW = $clog2(FIFO_WAIT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FIFO_WAIT - 1);

   localparam logic [3:0] A_SCR  = 4'd0;
   localparam logic [3:0] A_ARG  = 4'd1;
   localparam logic [3:0] A_CMD  = 4'd2;
   localparam logic [3:0] A_DAT  = 4'd3;
   localparam logic [3:0] A_PEND = 4'd4;
   localparam logic [3:0] A_EN   = 4'd5;
   localparam logic [3:0] A_FIFO = 4'd15;

   typedef enum logic [2:0] {
      IDLE,
      RX_WAIT,
      RX_POP,
      RX_DATA,
      TX_WAIT,
      ACK
   } state_t;

   state_t          state, state_next;
   logic [CW-1:0]   wait_cnt, wait_cnt_next;

   logic            accept;
   logic            is_fifo;
   logic            reg_wr;
   logic            reg_rd;
   logic            rx_capture;
   logic            tx_push;
   logic            fifo_tmo_evt;
   logic [31:0]     rd_data;
   logic [31:0]     rsp_word [4];

   logic [4:0]      irq_pend;
   logic [4:0]      irq_en;
   logic [4:0]      irq_set;
   logic [4:0]      irq_clr;
   logic            cmd_busy_q;
   logic            dat_busy_q;
   logic            cmd_done;
   logic            dat_done;

   logic [31:0]     data_q;
   logic [31:0]     tx_data_q;

   // A request is only taken while the FSM is idle; anything else is dropped.
   assign accept  = (state == IDLE) && i_request;
   assign is_fifo = (i_address == A_FIFO);
   assign reg_wr  = accept && i_write && !is_fifo;
   assign reg_rd  = accept && !i_write && !is_fifo;

   assign o_busy         = (state != IDLE);
   assign o_ack          = (state == ACK);
   assign o_rx_fifo_pop  = (state == RX_POP);
   assign o_tx_fifo_push = tx_push;
   assign o_tx_fifo_data = tx_data_q;
   assign o_data         = data_q;

   // Response words beyond RSP_WORDS read as zero.
   for (genvar w = 0; w < 4; w++) begin : g_rsp
      if (w < RSP_WORDS) begin : g_live
         assign rsp_word[w] = i_command_response[32*w +: 32];
      end else begin : g_zero
         assign rsp_word[w] = '0;
      end
   end

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      rx_capture    = 1'b0;
      tx_push       = 1'b0;
      fifo_tmo_evt  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               wait_cnt_next = '0;
               if (!is_fifo) begin
                  state_next = ACK;
               end else if (i_write) begin
                  // Writes always pass through TX_WAIT so the push comes from one place.
                  state_next = TX_WAIT;
               end else if (!i_rx_fifo_empty) begin
                  state_next = RX_POP;
               end else begin
                  state_next = RX_WAIT;
               end
            end
         end
         RX_WAIT: begin
            if (!i_rx_fifo_empty) begin
               state_next = RX_POP;
            end else if (wait_cnt == CNT_LAST) begin
               // Give up without popping; read data stays at the zero loaded on accept.
               state_next   = ACK;
               fifo_tmo_evt = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt + CW'(1);
            end
         end
         RX_POP: begin
            state_next = RX_DATA;
         end
         RX_DATA: begin
            // FIFO head word is valid the cycle after the pop.
            rx_capture = 1'b1;
            state_next = ACK;
         end
         TX_WAIT: begin
            if (!i_tx_fifo_full) begin
               tx_push    = 1'b1;
               state_next = ACK;
            end else if (wait_cnt == CNT_LAST) begin
               // Word is dropped.
               state_next   = ACK;
               fifo_tmo_evt = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt + CW'(1);
            end
         end
         ACK: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Read mux
   // ---------------------------------------------------------------
   always_comb begin
      rd_data = '0;
      case (i_address)
         A_SCR:  rd_data[2:0]  = o_sd_config;
         A_ARG:  rd_data       = o_command_argument;
         A_CMD:  rd_data[8:0]  = {i_command_status, i_command_index};
         A_DAT:  rd_data[22:0] = {i_tx_fifo_full, i_rx_fifo_empty, o_dat_num_blocks,
                                  o_dat_block_size, o_dat_direction, i_dat_status};
         A_PEND: rd_data[4:0]  = irq_pend;
         A_EN:   rd_data[4:0]  = irq_en;
         default: begin
            if (i_address[3] && ({1'b0, i_address[2:0]} < 4'(RSP_WORDS))) begin
               rd_data = rsp_word[i_address[1:0]];
            end
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Bus data path
   // ---------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         data_q    <= '0;
         tx_data_q <= '0;
      end else begin
         if (reg_rd) begin
            data_q <= rd_data;
         end else if (accept) begin
            data_q <= '0;
         end else if (rx_capture) begin
            data_q <= i_rx_fifo_data;
         end
         if (accept && is_fifo && i_write) begin
            tx_data_q <= i_data;
         end
      end
   end

   // ---------------------------------------------------------------
   // Control registers and one-cycle pulses
   // ---------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_sd_config        <= '0;
         o_command_argument <= '0;
         o_command_index    <= '0;
         o_command_flags    <= '0;
         o_command_start    <= 1'b0;
         o_dat_direction    <= 1'b0;
         o_dat_block_size   <= '0;
         o_dat_num_blocks   <= '0;
         o_dat_start        <= 1'b0;
         o_dat_stop         <= 1'b0;
         o_rx_fifo_flush    <= 1'b0;
         o_tx_fifo_flush    <= 1'b0;
         irq_en             <= '0;
      end else begin
         o_command_start <= reg_wr && (i_address == A_CMD) && i_data[6];
         o_dat_start     <= reg_wr && (i_address == A_DAT) && i_data[0];
         o_dat_stop      <= reg_wr && (i_address == A_DAT) && i_data[1];
         o_rx_fifo_flush <= reg_wr && (i_address == A_DAT) && i_data[21];
         o_tx_fifo_flush <= reg_wr && (i_address == A_DAT) && i_data[22];
         if (reg_wr) begin
            case (i_address)
               A_SCR: o_sd_config        <= i_data[2:0];
               A_ARG: o_command_argument <= i_data;
               A_CMD: begin
                  o_command_index <= i_data[5:0];
                  o_command_flags <= {i_data[8], i_data[7]};
               end
               A_DAT: begin
                  o_dat_direction  <= i_data[2];
                  o_dat_block_size <= i_data[9:3];
                  o_dat_num_blocks <= i_data[20:10];
               end
               A_EN:  irq_en <= i_data[4:0];
               default: ;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------
   // Interrupts: sticky pending bits, write-one-to-clear
   // ---------------------------------------------------------------
   assign cmd_done = cmd_busy_q && !i_command_status[0];
   assign dat_done = dat_busy_q && !i_dat_status[0];

   assign irq_set = {fifo_tmo_evt,
                     dat_done && i_dat_status[1],
                     dat_done,
                     cmd_done && (i_command_status[1] || i_command_status[2]),
                     cmd_done};
   assign irq_clr = (reg_wr && (i_address == A_PEND)) ? i_data[4:0] : 5'd0;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cmd_busy_q <= 1'b0;
         dat_busy_q <= 1'b0;
         irq_pend   <= '0;
         o_irq      <= 1'b0;
      end else begin
         cmd_busy_q <= i_command_status[0];
         dat_busy_q <= i_dat_status[0];
         // Set is applied after clear so a same-cycle event is never lost.
         irq_pend   <= (irq_pend & ~irq_clr) | irq_set;
         o_irq      <= |(irq_pend & irq_en);
      end
   end

endmodule

// File: tb/tb_sd_csr.sv
module tb_sd_csr;

   localparam int RSP_WORDS = 4;
   localparam int FIFO_WAIT = 15;

   logic                    i_clk;
   logic                    i_reset;
   logic [2:0]              o_sd_config;
   logic [5:0]              o_command_index;
   logic [31:0]             o_command_argument;
   logic [1:0]              o_command_flags;
   logic                    o_command_start;
   logic [5:0]              i_command_index;
   logic [32*RSP_WORDS-1:0] i_command_response;
   logic [2:0]              i_command_status;
   logic                    o_dat_direction;
   logic [6:0]              o_dat_block_size;
   logic [10:0]             o_dat_num_blocks;
   logic                    o_dat_start;
   logic                    o_dat_stop;
   logic [1:0]              i_dat_status;
   logic                    o_rx_fifo_flush;
   logic                    o_rx_fifo_pop;
   logic                    i_rx_fifo_empty;
   logic [31:0]             i_rx_fifo_data;
   logic                    o_tx_fifo_flush;
   logic                    o_tx_fifo_push;
   logic                    i_tx_fifo_full;
   logic [31:0]             o_tx_fifo_data;
   logic                    o_irq;
   logic                    i_request;
   logic                    i_write;
   logic [3:0]              i_address;
   logic [31:0]             i_data;
   logic                    o_busy;
   logic                    o_ack;
   logic [31:0]             o_data;

   sd_csr #(.RSP_WORDS(RSP_WORDS), .FIFO_WAIT(FIFO_WAIT)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .o_sd_config(o_sd_config), .o_command_index(o_command_index),
      .o_command_argument(o_command_argument), .o_command_flags(o_command_flags),
      .o_command_start(o_command_start), .i_command_index(i_command_index),
      .i_command_response(i_command_response), .i_command_status(i_command_status),
      .o_dat_direction(o_dat_direction), .o_dat_block_size(o_dat_block_size),
      .o_dat_num_blocks(o_dat_num_blocks), .o_dat_start(o_dat_start),
      .o_dat_stop(o_dat_stop), .i_dat_status(i_dat_status),
      .o_rx_fifo_flush(o_rx_fifo_flush), .o_rx_fifo_pop(o_rx_fifo_pop),
      .i_rx_fifo_empty(i_rx_fifo_empty), .i_rx_fifo_data(i_rx_fifo_data),
      .o_tx_fifo_flush(o_tx_fifo_flush), .o_tx_fifo_push(o_tx_fifo_push),
      .i_tx_fifo_full(i_tx_fifo_full), .o_tx_fifo_data(o_tx_fifo_data),
      .o_irq(o_irq), .i_request(i_request), .i_write(i_write),
      .i_address(i_address), .i_data(i_data), .o_busy(o_busy),
      .o_ack(o_ack), .o_data(o_data)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Scoreboard entry: pushed when a request is driven, popped on o_ack.
   typedef struct {
      bit          chk;
      logic [3:0]  addr;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      bit          wr;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } vec_t;

   exp_t        exp_q[$];
   vec_t        vecs[$];

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          req_cyc  = 0;
   int          ack_cyc  = 0;
   int          pop_cnt  = 0;
   int          pop_cyc  = 0;
   int          push_cnt = 0;
   int          push_cyc = 0;
   logic [31:0] push_dat = '0;
   logic [31:0] rx_head  = '0;
   bit          ack_flag = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Samples the current cycle at the falling edge, then advances to just
   // after the next rising edge where the caller drives the next cycle.
   task automatic step();
      bit   pop_now;
      exp_t e;
      @(negedge i_clk);
      pop_now = o_rx_fifo_pop;
      if (o_ack) begin
         ack_flag = 1'b1;
         ack_cyc  = cyc;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ack: got ack with data %h, expected none (cycle %0d)", o_data, cyc);
         end else begin
            e = exp_q.pop_front();
            if (e.chk) chk($sformatf("rd_data addr %0d", e.addr), o_data, e.data);
         end
      end
      if (o_rx_fifo_pop) begin
         pop_cnt++;
         pop_cyc = cyc;
      end
      if (o_tx_fifo_push) begin
         push_cnt++;
         push_cyc = cyc;
         push_dat = o_tx_fifo_data;
      end
      @(posedge i_clk);
      #1;
      cyc++;
      // Single-word RX FIFO model: head word appears the cycle after the pop.
      if (pop_now) begin
         i_rx_fifo_data  = rx_head;
         i_rx_fifo_empty = 1'b1;
      end else begin
         i_rx_fifo_data  = 32'hBAD0_BAD0;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (o_busy && n < 50) begin
         step();
         n++;
      end
      chk("idle_wait", {31'd0, o_busy}, 32'd0);
   endtask

   task automatic issue(input bit wr, input logic [3:0] a, input logic [31:0] d,
                        input bit chkd, input logic [31:0] expd);
      exp_t e;
      wait_idle();
      i_request = 1'b1;
      i_write   = wr;
      i_address = a;
      i_data    = d;
      req_cyc   = cyc;
      ack_flag  = 1'b0;
      e.chk  = chkd;
      e.addr = a;
      e.data = expd;
      exp_q.push_back(e);
      step();
      i_request = 1'b0;
      i_write   = 1'b0;
      i_data    = '0;
   endtask

   task automatic wait_ack(input int budget, input int lat);
      int n = 0;
      while (!ack_flag && n < budget) begin
         step();
         n++;
      end
      chk("ack_seen", {31'd0, ack_flag}, 32'd1);
      chk("ack_latency", 32'(ack_cyc - req_cyc), 32'(lat));
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      issue(1'b1, a, d, 1'b0, '0);
      wait_ack(10, 1);
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] expd);
      issue(1'b0, a, '0, 1'b1, expd);
      wait_ack(10, 1);
   endtask

   function automatic vec_t mkv(input bit w, input logic [3:0] a,
                                input logic [31:0] wd, input logic [31:0] rdv);
      vec_t v;
      v.wr = w; v.addr = a; v.wdata = wd; v.rdata = rdv;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      // Register vectors: writes then read-backs with their expected values.
      vecs.push_back(mkv(1'b1, 4'd0, 32'hFFFF_FFFD, '0));
      vecs.push_back(mkv(1'b0, 4'd0, '0, 32'h0000_0005));
      vecs.push_back(mkv(1'b1, 4'd1, 32'hA5A5_1234, '0));
      vecs.push_back(mkv(1'b0, 4'd1, '0, 32'hA5A5_1234));
      vecs.push_back(mkv(1'b1, 4'd3, {9'd0, 2'b00, 11'h123, 7'h40, 1'b1, 2'b00}, '0));
      vecs.push_back(mkv(1'b0, 4'd3, '0, {9'd0, 1'b0, 1'b1, 11'h123, 7'h40, 1'b1, 2'b00}));
      vecs.push_back(mkv(1'b1, 4'd6, 32'hDEAD_BEEF, '0));
      vecs.push_back(mkv(1'b0, 4'd6, '0, 32'h0));
      vecs.push_back(mkv(1'b1, 4'd7, 32'hFFFF_FFFF, '0));
      vecs.push_back(mkv(1'b0, 4'd7, '0, 32'h0));
      vecs.push_back(mkv(1'b1, 4'd5, 32'h0000_003F, '0));
      vecs.push_back(mkv(1'b0, 4'd5, '0, 32'h0000_001F));
      vecs.push_back(mkv(1'b0, 4'd4, '0, 32'h0));
      vecs.push_back(mkv(1'b0, 4'd8, '0, 32'h1111_1111));
      vecs.push_back(mkv(1'b0, 4'd9, '0, 32'h2222_2222));
      vecs.push_back(mkv(1'b0, 4'd10, '0, 32'h3333_3333));
      vecs.push_back(mkv(1'b0, 4'd11, '0, 32'h4444_4444));
      vecs.push_back(mkv(1'b0, 4'd12, '0, 32'h0));
      vecs.push_back(mkv(1'b0, 4'd14, '0, 32'h0));

      i_reset            = 1'b1;
      i_command_index    = '0;
      i_command_response = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
      i_command_status   = '0;
      i_dat_status       = '0;
      i_rx_fifo_empty    = 1'b1;
      i_rx_fifo_data     = 32'hBAD0_BAD0;
      i_tx_fifo_full     = 1'b0;
      i_request          = 1'b0;
      i_write            = 1'b0;
      i_address          = '0;
      i_data             = '0;

      repeat (3) step();
      chk("rst_cfg", {1'b0, o_sd_config, o_command_index, o_command_flags, o_command_start,
                      o_dat_direction, o_dat_block_size, o_dat_num_blocks}, 32'd0);
      chk("rst_arg", o_command_argument, 32'd0);
      chk("rst_ctl", {23'd0, o_dat_start, o_dat_stop, o_rx_fifo_flush, o_rx_fifo_pop,
                      o_tx_fifo_flush, o_tx_fifo_push, o_irq, o_busy, o_ack}, 32'd0);
      chk("rst_data", o_data, 32'd0);
      chk("rst_txdata", o_tx_fifo_data, 32'd0);
      i_reset = 1'b0;

      // CMD write with start/long/skip, then status read while busy.
      i_command_index = 6'd8;
      issue(1'b1, 4'd2, 32'h0000_01C8, 1'b0, '0);
      chk("cmd_start", {31'd0, o_command_start}, 32'd1);
      chk("cmd_index", {26'd0, o_command_index}, 32'd8);
      chk("cmd_flags", {30'd0, o_command_flags}, 32'd3);
      wait_ack(10, 1);
      chk("cmd_start_off", {31'd0, o_command_start}, 32'd0);
      i_command_status = 3'b001;
      rd(4'd2, 32'h0000_0048);

      // Register table.
      foreach (vecs[i]) begin
         if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
         else            rd(vecs[i].addr, vecs[i].rdata);
      end
      chk("sd_config", {29'd0, o_sd_config}, 32'd5);
      chk("cmd_arg", o_command_argument, 32'hA5A5_1234);
      chk("dat_fields", {13'd0, o_dat_direction, o_dat_block_size, o_dat_num_blocks},
          {13'd0, 1'b1, 7'h40, 11'h123});

      // DAT write pulses: start, stop, rx flush, tx flush for exactly one cycle.
      issue(1'b1, 4'd3, {9'd0, 2'b11, 11'h123, 7'h40, 1'b1, 2'b11}, 1'b0, '0);
      chk("dat_pulses", {28'd0, o_dat_start, o_dat_stop, o_rx_fifo_flush, o_tx_fifo_flush}, 32'hF);
      wait_ack(10, 1);
      chk("dat_pulses_off", {28'd0, o_dat_start, o_dat_stop, o_rx_fifo_flush, o_tx_fifo_flush}, 32'h0);

      // Command done with timeout: pending 0x3, o_irq one cycle later.
      wr(4'd5, 32'h3);
      i_command_status = 3'b010;
      step();
      i_command_status = 3'b000;
      chk("irq_lag", {31'd0, o_irq}, 32'd0);
      step();
      chk("irq_set", {31'd0, o_irq}, 32'd1);
      rd(4'd4, 32'h3);

      // Clear of bit 0 in the same cycle as a new done event: set wins.
      i_command_status = 3'b001;
      step();
      step();
      wait_idle();
      i_command_status = 3'b000;
      issue(1'b1, 4'd4, 32'h1, 1'b0, '0);
      wait_ack(10, 1);
      rd(4'd4, 32'h3);
      wr(4'd4, 32'h3);
      rd(4'd4, 32'h0);
      chk("irq_clear", {31'd0, o_irq}, 32'd0);

      // Data engine done with CRC error: bits 2 and 3, masked from o_irq.
      i_dat_status = 2'b01;
      step();
      step();
      i_dat_status = 2'b10;
      step();
      i_dat_status = 2'b00;
      rd(4'd4, 32'hC);
      chk("irq_masked", {31'd0, o_irq}, 32'd0);

      // FIFO read with data waiting: pop at N+1, ack at N+3.
      rx_head         = 32'hDEAD_BEEF;
      i_rx_fifo_empty = 1'b0;
      pop_cnt         = 0;
      issue(1'b0, 4'd15, '0, 1'b1, 32'hDEAD_BEEF);
      wait_ack(20, 3);
      chk("rx_pop_count", 32'(pop_cnt), 32'd1);
      chk("rx_pop_cycle", 32'(pop_cyc - req_cyc), 32'd1);

      // FIFO read on an empty FIFO: timeout after FIFO_WAIT stall cycles, data 0, no pop.
      i_rx_fifo_empty = 1'b1;
      pop_cnt         = 0;
      issue(1'b0, 4'd15, '0, 1'b1, 32'h0);
      wait_ack(40, FIFO_WAIT + 1);
      chk("rx_tmo_no_pop", 32'(pop_cnt), 32'd0);
      rd(4'd4, 32'h1C);

      // FIFO write with TX full for 3 cycles, then room: one push, then ack.
      i_tx_fifo_full = 1'b1;
      push_cnt       = 0;
      issue(1'b1, 4'd15, 32'h1234_5678, 1'b0, '0);
      step();
      step();
      i_tx_fifo_full = 1'b0;
      wait_ack(20, 4);
      chk("tx_push_count", 32'(push_cnt), 32'd1);
      chk("tx_push_data", push_dat, 32'h1234_5678);
      chk("tx_push_cycle", 32'(push_cyc - req_cyc), 32'd3);

      // FIFO write with TX full throughout: word dropped, fifo_tmo set.
      wr(4'd4, 32'h10);
      i_tx_fifo_full = 1'b1;
      push_cnt       = 0;
      issue(1'b1, 4'd15, 32'hCAFE_F00D, 1'b0, '0);
      wait_ack(40, FIFO_WAIT + 1);
      chk("tx_tmo_no_push", 32'(push_cnt), 32'd0);
      i_tx_fifo_full = 1'b0;
      rd(4'd4, 32'h1C);

      // Reset while stalled in RX_WAIT: no ack, busy drops, no later pop.
      i_rx_fifo_empty = 1'b1;
      issue(1'b0, 4'd15, '0, 1'b1, 32'h0);
      step();
      step();
      chk("rst_mid_busy", {31'd0, o_busy}, 32'd1);
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      exp_q.delete();
      chk("rst_mid_idle", {31'd0, o_busy}, 32'd0);
      ack_flag        = 1'b0;
      pop_cnt         = 0;
      i_rx_fifo_empty = 1'b0;
      rx_head         = 32'h5555_AAAA;
      repeat (20) step();
      chk("rst_mid_no_ack", {31'd0, ack_flag}, 32'd0);
      chk("rst_mid_no_pop", 32'(pop_cnt), 32'd0);
      i_rx_fifo_empty = 1'b1;
      rd(4'd4, 32'h0);
      rd(4'd0, 32'h0);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
